instr_fetch_unit: RTL

//  Multicycle fetch stage upstream of the control FSM. It owns the PC and the instruction register (IR).

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: owns PC and IR, req/ack imem read with timeout.
// Optional MISALIGN_CHECK_EN: misaligned fetch traps to ERR instead of being aligned.
module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_en,
   input  logic            pc_load,
   input  logic [XLEN-1:0] pc_next,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic [XLEN-1:0] pc_cur,
   output logic [XLEN-1:0] pc,
   output logic            instr_valid,
   output logic            fetch_busy,
   output logic            fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR
   } state_t;

   localparam logic [31:0]     NOP     = 32'h0000_0013;
   localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);
   localparam logic [XLEN-1:0] STEP    = XLEN'(4);

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_cur_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] pend_q;
   logic            pend_v_q;
   logic [7:0]      cnt_q;
   logic [31:0]     instr_q;
   logic            req_q;
   logic            valid_q;
   logic            err_q;
   logic [XLEN-1:0] fetch_pc;

   // Address of a fetch launched this cycle; a same-cycle pc_load wins
   always_comb begin
      fetch_pc = pc_load ? pc_next : pc_q;
   end

`ifndef MISALIGN_CHECK_EN
   logic [XLEN-1:0] fetch_al;

   // Low address bits are dropped rather than trapped
   always_comb begin
      fetch_al = fetch_pc & ~XLEN'(3);
   end
`endif

   // Fetch FSM: all outputs registered, ack wins over timeout in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         pc_cur_q <= RESET_PC;
         addr_q   <= RESET_PC;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         cnt_q    <= '0;
         instr_q  <= NOP;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (pc_load) begin
                  pc_q <= pc_next;
               end
               if (fetch_en) begin
`ifdef MISALIGN_CHECK_EN
                  if (fetch_pc[1:0] != 2'b00) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                     instr_q <= '0;
                  end else begin
                     state_q  <= S_WAIT;
                     req_q    <= 1'b1;
                     addr_q   <= fetch_pc;
                     cnt_q    <= '0;
                     pend_v_q <= 1'b0;
                  end
`else
                  state_q  <= S_WAIT;
                  req_q    <= 1'b1;
                  addr_q   <= fetch_al;
                  cnt_q    <= '0;
                  pend_v_q <= 1'b0;
`endif
               end
            end
            S_WAIT: begin
               if (imem_ack) begin
                  state_q  <= S_IDLE;
                  instr_q  <= imem_rdata;
                  pc_cur_q <= addr_q;
                  req_q    <= 1'b0;
                  valid_q  <= 1'b1;
                  pend_v_q <= 1'b0;
                  if (pc_load) begin
                     pc_q <= pc_next;
                  end else if (pend_v_q) begin
                     pc_q <= pend_q;
                  end else begin
                     pc_q <= addr_q + STEP;
                  end
               end else if (cnt_q == TO_LAST) begin
                  state_q <= S_ERR;
                  instr_q <= '0;
                  err_q   <= 1'b1;
                  req_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  if (pc_load) begin
                     pend_q   <= pc_next;
                     pend_v_q <= 1'b1;
                  end
               end
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign pc_cur      = pc_cur_q;
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign fetch_busy  = (state_q == S_WAIT);
   assign fetch_err   = err_q;

endmodule
